// File: rtl/matrix_frame_buffer.sv
// matrix_frame_buffer
// N-way (2 or 3 slot) frame buffer for the LED matrix datapath. Every channel
// owns NUM_BUFFERS slots. The packer writes wide words into the slot at
// wr_idx, and the streamer reads narrow sub-words from the slot at rd_idx.
// Slots are exchanged only at frame boundaries, so the reader never sees a
// frame that is half written.
//
// Three slots: the writer never stalls. A finished frame that the reader has
// not picked up yet is replaced by the next finished frame, and that counts
// as a drop. Two slots: after frame_done the writer is held off until the
// reader takes the frame.
//
// Optional build macro MATRIX_FB_STATS_EN: when defined, O_frame_count and
// O_drop_count are live saturating counters. When not defined, both ports
// are tied to zero and no counter logic is built.
//
// Handshake summary:
//   - The writer may write or pulse I_wr_frame_done only while O_wr_ready=1.
//     Strobes given while O_wr_ready=0 are ignored.
//   - Each I_rd_en returns one O_rd_valid pulse exactly one cycle later.
//   - A read issued in the same cycle as I_rd_frame_start sees the frame
//     selected by that exchange.

module matrix_frame_buffer #(
    parameter int NUM_BUFFERS       = 3,
    parameter int CHANNELS          = 12,
    parameter int BYTES_PER_CHANNEL = 2250,
    parameter int WR_WIDTH          = 32,
    parameter int RD_WIDTH          = 8,
    parameter int WR_DEPTH          = BYTES_PER_CHANNEL * 8 / WR_WIDTH,
    parameter int RD_DEPTH          = BYTES_PER_CHANNEL * 8 / RD_WIDTH
) (
    input  logic                           I_clk,
    input  logic                           I_rst_n,
    input  logic                           I_wr_en,
    input  logic [$clog2(WR_DEPTH)-1:0]    I_wr_addr,
    input  logic [CHANNELS*WR_WIDTH-1:0]   I_wr_data_flat,
    input  logic                           I_wr_frame_done,
    output logic                           O_wr_ready,
    input  logic                           I_rd_frame_start,
    input  logic                           I_rd_en,
    input  logic [$clog2(RD_DEPTH)-1:0]    I_rd_addr,
    output logic [CHANNELS*RD_WIDTH-1:0]   O_rd_data_flat,
    output logic                           O_rd_valid,
    output logic                           O_data_valid,
    output logic [15:0]                    O_frame_count,
    output logic [15:0]                    O_drop_count
);

    // Number of read sub-words that make up one write word. Lane 0 holds the
    // least significant bits of the write word.
    localparam int RATIO     = WR_WIDTH / RD_WIDTH;
    localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MEM_DEPTH = NUM_BUFFERS * WR_DEPTH;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int DW        = CHANNELS * WR_WIDTH;
    localparam int RW        = CHANNELS * RD_WIDTH;

    // Slot bookkeeping
    logic [1:0] wr_idx, rd_idx, ready_idx;
    logic       ready_flag;
    logic       wr_ready_q;
    logic       data_valid_q;

    logic [1:0] nxt_wr_idx, nxt_rd_idx, nxt_ready_idx;
    logic       nxt_ready_flag;
    logic       nxt_wr_ready;
    logic       nxt_data_valid;

    // frame_done only counts while the writer is allowed to write.
    logic       fd_acc;
    logic       fs;

    assign fd_acc = I_wr_frame_done && wr_ready_q;
    assign fs     = I_rd_frame_start;

    // Storage. All channels share one address, so one wide word holds every
    // channel. Slot s occupies words [s*WR_DEPTH, (s+1)*WR_DEPTH).
    logic [DW-1:0] mem [MEM_DEPTH];

    // Write path
    logic              wr_ok;
    logic [MEM_AW-1:0] wr_mem_addr;

    // Read path
    int                rd_addr_i;
    int                rd_word_i;
    int                rd_lane_i;
    logic              rd_hit;
    logic [MEM_AW-1:0] rd_mem_addr;
    logic [DW-1:0]     rd_word_q;
    logic [LANE_W-1:0] rd_lane_q;
    logic              rd_hit_q;
    logic              rd_valid_q;
    logic [RW-1:0]     rd_data;

    // Next-state for the slot exchange. When frame_done and frame_start occur
    // together, frame_done is resolved first and the reader then takes the
    // frame that has just completed.
    always_comb begin
        nxt_wr_idx     = wr_idx;
        nxt_rd_idx     = rd_idx;
        nxt_ready_idx  = ready_idx;
        nxt_ready_flag = ready_flag;
        nxt_wr_ready   = wr_ready_q;
        nxt_data_valid = data_valid_q;
        if (NUM_BUFFERS == 3) begin
            if (fd_acc && fs) begin
                nxt_rd_idx     = wr_idx;
                nxt_wr_idx     = ready_idx;
                nxt_ready_idx  = rd_idx;
                nxt_ready_flag = 1'b0;
                nxt_data_valid = 1'b1;
            end else if (fd_acc) begin
                nxt_ready_idx  = wr_idx;
                nxt_wr_idx     = ready_idx;
                nxt_ready_flag = 1'b1;
            end else if (fs && ready_flag) begin
                nxt_rd_idx     = ready_idx;
                nxt_ready_idx  = rd_idx;
                nxt_ready_flag = 1'b0;
                nxt_data_valid = 1'b1;
            end
            nxt_wr_ready = 1'b1;
        end else begin
            if (fd_acc && fs) begin
                nxt_wr_idx     = rd_idx;
                nxt_rd_idx     = wr_idx;
                nxt_ready_flag = 1'b0;
                nxt_wr_ready   = 1'b1;
                nxt_data_valid = 1'b1;
            end else if (fd_acc) begin
                nxt_ready_flag = 1'b1;
                nxt_wr_ready   = 1'b0;
            end else if (fs && ready_flag) begin
                nxt_wr_idx     = rd_idx;
                nxt_rd_idx     = wr_idx;
                nxt_ready_flag = 1'b0;
                nxt_wr_ready   = 1'b1;
                nxt_data_valid = 1'b1;
            end
        end
    end

    // Exchange state registers. On reset the reader holds slot 1 and slot 2
    // is the spare; any partially written frame is abandoned.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            wr_idx       <= 2'd0;
            rd_idx       <= 2'd1;
            ready_idx    <= 2'd2;
            ready_flag   <= 1'b0;
            wr_ready_q   <= 1'b1;
            data_valid_q <= 1'b0;
        end else begin
            wr_idx       <= nxt_wr_idx;
            rd_idx       <= nxt_rd_idx;
            ready_idx    <= nxt_ready_idx;
            ready_flag   <= nxt_ready_flag;
            wr_ready_q   <= nxt_wr_ready;
            data_valid_q <= nxt_data_valid;
        end
    end

    assign O_wr_ready   = wr_ready_q;
    assign O_data_valid = data_valid_q;

    // A write lands in the slot the writer holds before this edge, so a word
    // written together with frame_done still belongs to the frame it ends.
    assign wr_ok       = I_wr_en && wr_ready_q && (int'(I_wr_addr) < WR_DEPTH);
    assign wr_mem_addr = MEM_AW'(int'(wr_idx) * WR_DEPTH + int'(I_wr_addr));

    // RAM write port: one wide word covering all channels
    always_ff @(posedge I_clk) begin
        if (wr_ok) begin
            mem[wr_mem_addr] <= I_wr_data_flat;
        end
    end

    // Split the narrow read address into a word address and a lane. The read
    // uses the post-exchange slot and validity, so a read issued together
    // with frame_start already sees the new frame. Addresses beyond the
    // stored frame return zero.
    always_comb begin
        rd_addr_i   = int'(I_rd_addr);
        rd_word_i   = rd_addr_i / RATIO;
        rd_lane_i   = rd_addr_i % RATIO;
        rd_hit      = nxt_data_valid && (rd_addr_i < RD_DEPTH) && (rd_word_i < WR_DEPTH);
        rd_mem_addr = '0;
        if (rd_hit) begin
            rd_mem_addr = MEM_AW'(int'(nxt_rd_idx) * WR_DEPTH + rd_word_i);
        end
    end

    // RAM read port: synchronous read, with no reset so it can map to block RAM
    always_ff @(posedge I_clk) begin
        if (I_rd_en) begin
            rd_word_q <= mem[rd_mem_addr];
        end
    end

    // Read-side control pipeline: valid, hit and lane, aligned with rd_word_q
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_lane_q  <= '0;
        end else begin
            rd_valid_q <= I_rd_en;
            if (I_rd_en) begin
                rd_hit_q  <= rd_hit;
                rd_lane_q <= LANE_W'(rd_lane_i);
            end
        end
    end

    // Pick the selected lane from each channel's word; zero when there is no hit
    always_comb begin
        rd_data = '0;
        if (rd_hit_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                rd_data[c*RD_WIDTH +: RD_WIDTH] =
                    rd_word_q[c*WR_WIDTH + int'(rd_lane_q)*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

    assign O_rd_data_flat = rd_data;
    assign O_rd_valid     = rd_valid_q;

`ifdef MATRIX_FB_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        drop_evt;

    // A ready frame replaced before display is a drop. This happens only with
    // three slots; with two slots the writer is stalled instead.
    assign drop_evt = fd_acc && ready_flag && (NUM_BUFFERS == 3);

    // Saturating statistics counters
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            frame_cnt <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            if (fd_acc && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (drop_evt && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign O_frame_count = frame_cnt;
    assign O_drop_count  = drop_cnt;
`else
    assign O_frame_count = 16'd0;
    assign O_drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Testbench for matrix_frame_buffer: one triple-buffer instance (index 0) and
// one double-buffer instance (index 1) driven from directed vectors. Expected
// read data goes into per-instance queues, and a monitor pops a queue entry
// for every O_rd_valid.

module tb_matrix_frame_buffer;

    localparam int CH       = 12;
    localparam int BPC      = 2250;
    localparam int WW       = 32;
    localparam int RWD      = 8;
    localparam int WR_DEPTH = BPC * 8 / WW;   // 562
    localparam int RD_DEPTH = BPC * 8 / RWD;  // 2250
    localparam int WA       = $clog2(WR_DEPTH);
    localparam int RA       = $clog2(RD_DEPTH);

`ifdef MATRIX_FB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              wr_en    [2];
    logic [WA-1:0]     wr_addr  [2];
    logic [CH*WW-1:0]  wr_data  [2];
    logic              wr_fd    [2];
    logic              wr_ready [2];
    logic              rd_fs    [2];
    logic              rd_en    [2];
    logic [RA-1:0]     rd_addr  [2];
    logic [CH*RWD-1:0] rd_data  [2];
    logic              rd_valid [2];
    logic              data_valid [2];
    logic [15:0]       frame_cnt  [2];
    logic [15:0]       drop_cnt   [2];

    logic [CH*RWD-1:0] exp_q0[$];
    logic [CH*RWD-1:0] exp_q1[$];

    int n_vec = 0;
    int n_bad = 0;

    matrix_frame_buffer #(.NUM_BUFFERS(3)) dut3 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_wr_en(wr_en[0]), .I_wr_addr(wr_addr[0]), .I_wr_data_flat(wr_data[0]),
        .I_wr_frame_done(wr_fd[0]), .O_wr_ready(wr_ready[0]),
        .I_rd_frame_start(rd_fs[0]), .I_rd_en(rd_en[0]), .I_rd_addr(rd_addr[0]),
        .O_rd_data_flat(rd_data[0]), .O_rd_valid(rd_valid[0]),
        .O_data_valid(data_valid[0]), .O_frame_count(frame_cnt[0]),
        .O_drop_count(drop_cnt[0])
    );

    matrix_frame_buffer #(.NUM_BUFFERS(2)) dut2 (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_wr_en(wr_en[1]), .I_wr_addr(wr_addr[1]), .I_wr_data_flat(wr_data[1]),
        .I_wr_frame_done(wr_fd[1]), .O_wr_ready(wr_ready[1]),
        .I_rd_frame_start(rd_fs[1]), .I_rd_en(rd_en[1]), .I_rd_addr(rd_addr[1]),
        .O_rd_data_flat(rd_data[1]), .O_rd_valid(rd_valid[1]),
        .O_data_valid(data_valid[1]), .O_frame_count(frame_cnt[1]),
        .O_drop_count(drop_cnt[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every O_rd_valid consumes one expected read result
    always @(posedge clk) begin
        #1;
        if (rd_valid[0]) begin
            n_vec++;
            if (exp_q0.size() == 0) begin
                n_bad++;
                $display("FAIL rd3_unexpected_valid: got data %0h expected no valid", rd_data[0]);
            end else begin
                logic [CH*RWD-1:0] e;
                e = exp_q0.pop_front();
                if (rd_data[0] !== e) begin
                    n_bad++;
                    $display("FAIL rd3_data: got %0h expected %0h", rd_data[0], e);
                end
            end
        end
        if (rd_valid[1]) begin
            n_vec++;
            if (exp_q1.size() == 0) begin
                n_bad++;
                $display("FAIL rd2_unexpected_valid: got data %0h expected no valid", rd_data[1]);
            end else begin
                logic [CH*RWD-1:0] e;
                e = exp_q1.pop_front();
                if (rd_data[1] !== e) begin
                    n_bad++;
                    $display("FAIL rd2_data: got %0h expected %0h", rd_data[1], e);
                end
            end
        end
    end

    // Driver tasks; inputs change on the falling edge
    task automatic write_word(input int s, input int a, input logic [31:0] pat);
        wr_en[s]   = 1'b1;
        wr_addr[s] = WA'(a);
        wr_data[s] = {CH{pat}};
        @(negedge clk);
        wr_en[s]   = 1'b0;
    endtask

    task automatic write_frame(input int s, input logic [31:0] pat);
        for (int a = 0; a < WR_DEPTH; a++) begin
            write_word(s, a, pat);
        end
    endtask

    task automatic pulse_fd(input int s);
        wr_fd[s] = 1'b1;
        @(negedge clk);
        wr_fd[s] = 1'b0;
    endtask

    task automatic pulse_fs(input int s);
        rd_fs[s] = 1'b1;
        @(negedge clk);
        rd_fs[s] = 1'b0;
    endtask

    // Issue one read and queue the byte expected on every channel
    task automatic do_read(input int s, input int a, input logic [7:0] eb);
        rd_en[s]   = 1'b1;
        rd_addr[s] = RA'(a);
        if (s == 0) exp_q0.push_back({CH{eb}});
        else        exp_q1.push_back({CH{eb}});
        @(negedge clk);
        rd_en[s]   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            wr_en[s] = 1'b0; wr_addr[s] = '0; wr_data[s] = '0; wr_fd[s] = 1'b0;
            rd_fs[s] = 1'b0; rd_en[s] = 1'b0; rd_addr[s] = '0;
        end
        @(negedge clk);
        apply_reset();

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            check("rst_wr_ready", 32'(wr_ready[s]), 32'd1);
            check("rst_data_valid", 32'(data_valid[s]), 32'd0);
            check("rst_rd_valid", 32'(rd_valid[s]), 32'd0);
            check("rst_rd_data", 32'(rd_data[s] != '0), 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt[s]), 32'd0);
            check("rst_drop_cnt", 32'(drop_cnt[s]), 32'd0);
            do_read(s, 0, 8'h00);
        end
        check("rst_dv_after_read", 32'(data_valid[0]), 32'd0);

        // Triple buffer: full frame, lane order, last word, out of range
        write_frame(0, 32'hDDCCBBAA);
        pulse_fd(0);
        check("t3_dv_before_start", 32'(data_valid[0]), 32'd0);
        do_read(0, 0, 8'h00);
        pulse_fs(0);
        check("t3_dv_after_start", 32'(data_valid[0]), 32'd1);
        do_read(0, 0, 8'hAA);
        do_read(0, 1, 8'hBB);
        do_read(0, 2, 8'hCC);
        do_read(0, 3, 8'hDD);
        do_read(0, 4*WR_DEPTH-1, 8'hDD);
        do_read(0, RD_DEPTH, 8'h00);
        check("t3_frame_cnt_1", 32'(frame_cnt[0]), STATS ? 32'd1 : 32'd0);
        check("t3_wr_ready", 32'(wr_ready[0]), 32'd1);
        repeat (2) @(negedge clk);

        // Triple buffer: two completed frames without a start, then start
        apply_reset();
        write_frame(0, 32'h11111111);
        pulse_fd(0);
        write_frame(0, 32'h22222222);
        pulse_fd(0);
        check("t3_wr_ready_no_stall", 32'(wr_ready[0]), 32'd1);
        pulse_fs(0);
        for (int a = 0; a < 4; a++) do_read(0, a, 8'h22);
        check("t3_frame_cnt_2", 32'(frame_cnt[0]), STATS ? 32'd2 : 32'd0);
        check("t3_drop_cnt_1", 32'(drop_cnt[0]), STATS ? 32'd1 : 32'd0);

        // Triple buffer: frame_done, frame_start and a read all in one cycle
        write_frame(0, 32'h33333333);
        wr_fd[0] = 1'b1;
        rd_fs[0] = 1'b1;
        do_read(0, 5, 8'h33);
        wr_fd[0] = 1'b0;
        rd_fs[0] = 1'b0;
        for (int a = 0; a < 4; a++) write_word(0, a, 32'h44444444);
        for (int a = 0; a < 4; a++) do_read(0, a, 8'h33);
        // Start with nothing ready: same frame repeats
        rd_fs[0] = 1'b1;
        do_read(0, 1, 8'h33);
        rd_fs[0] = 1'b0;
        do_read(0, 4*WR_DEPTH-1, 8'h33);
        do_read(0, RD_DEPTH, 8'h00);
        check("t3_frame_cnt_3", 32'(frame_cnt[0]), STATS ? 32'd3 : 32'd0);
        check("t3_drop_cnt_hold", 32'(drop_cnt[0]), STATS ? 32'd1 : 32'd0);
        check("t3_dv_hold", 32'(data_valid[0]), 32'd1);

        // Double buffer: stall after frame_done, dropped write, swap
        write_frame(1, 32'h66666666);
        pulse_fd(1);
        check("t2_wr_ready_stall", 32'(wr_ready[1]), 32'd0);
        write_word(1, 0, 32'h55555555);
        pulse_fd(1);
        check("t2_frame_cnt_ignored", 32'(frame_cnt[1]), STATS ? 32'd1 : 32'd0);
        pulse_fs(1);
        check("t2_wr_ready_released", 32'(wr_ready[1]), 32'd1);
        check("t2_dv", 32'(data_valid[1]), 32'd1);
        for (int a = 0; a < 4; a++) do_read(1, a, 8'h66);
        check("t2_drop_cnt", 32'(drop_cnt[1]), 32'd0);

        // Double buffer: simultaneous frame_done and frame_start
        write_word(1, 0, 32'h77777777);
        wr_fd[1] = 1'b1;
        rd_fs[1] = 1'b1;
        @(negedge clk);
        wr_fd[1] = 1'b0;
        rd_fs[1] = 1'b0;
        check("t2_sim_wr_ready", 32'(wr_ready[1]), 32'd1);
        do_read(1, 0, 8'h77);
        do_read(1, 1, 8'h77);
        check("t2_frame_cnt_2", 32'(frame_cnt[1]), STATS ? 32'd2 : 32'd0);
        check("t2_drop_cnt_zero", 32'(drop_cnt[1]), 32'd0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a write burst
        wr_en[0]   = 1'b1;
        wr_addr[0] = '0;
        wr_data[0] = {CH{32'h99999999}};
        @(negedge clk);
        wr_addr[0] = WA'(1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(negedge clk);
        wr_en[0] = 1'b0;
        check("mid_rst_dv3", 32'(data_valid[0]), 32'd0);
        check("mid_rst_dv2", 32'(data_valid[1]), 32'd0);
        check("mid_rst_wr_ready3", 32'(wr_ready[0]), 32'd1);
        check("mid_rst_wr_ready2", 32'(wr_ready[1]), 32'd1);
        check("mid_rst_rd_valid", 32'(rd_valid[0]), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, RD_DEPTH, 8'h00);
        do_read(0, 0, 8'h00);

        // Drain outstanding reads and confirm every expected read arrived
        repeat (3) @(negedge clk);
        check("q3_drained", 32'(exp_q0.size()), 32'd0);
        check("q2_drained", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
